rain_window_ctrl: RTL and testbench

- Controller that turns the rain sensor into a sequenced window actuator.
- Debounces the raw rain input and produces the rain alarm.
- Closes the window motor on rain and reopens it after a dry hold period, with limit switches, timeouts and a fault trap.
- Sits between the rain sensing path and the window motor driver in the smart home top level.

---
 rtl/rain_window_ctrl_pkg.sv | 33 +++
 rtl/rain_window_ctrl_if.sv | 60 ++++++
 rtl/rain_window_ctrl_sensor_debounce.sv | 52 +++++
 rtl/rain_window_ctrl.sv | 174 +++++++++++++++++
 tb/tb_rain_window_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/rain_window_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rain_window_ctrl_pkg
// Description : Shared types and default values for the rain window
//               controller. Holds the state encoding, the default parameter
//               values and a small helper that identifies motor-driving states.
// Revision    : 1.0 - initial release
// ============================================================================
package rain_window_ctrl_pkg;

    // The state encoding is visible on state_o, so the values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE_OPEN = 3'd0,
        ST_CLOSING   = 3'd1,
        ST_CLOSED    = 3'd2,
        ST_WAIT_DRY  = 3'd3,
        ST_OPENING   = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    localparam int unsigned C_DEBOUNCE_CYCLES_DEF = 4;
    localparam int unsigned C_MOTOR_TIMEOUT_DEF   = 32;
    localparam int unsigned C_DRY_HOLD_DEF        = 16;
    localparam int unsigned C_CNT_W_DEF           = 8;

    // True for the states in which a motor is energised and the motor
    // timer is running.
    function automatic logic is_motion(input state_t s);
        return (s == ST_CLOSING) || (s == ST_OPENING);
    endfunction

endpackage : rain_window_ctrl_pkg
`default_nettype wire

// File: rtl/rain_window_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : rain_window_ctrl_if
// Description : Sensor/actuator bundle between the rain window controller
//               and the rest of the smart home top level.
//   rain_sensor   : raw rain sensor, 1 = wet
//   win_closed_sw : limit switch, 1 = window fully closed
//   win_open_sw   : limit switch, 1 = window fully open
//   auto_en       : 1 = automatic close/reopen enabled
//   manual_open   : level request to open (honoured only when dry)
//   motor_close   : drive motor in close direction
//   motor_open    : drive motor in open direction
//   rain_alarm    : filtered rain level
//   fault         : sticky fault flag
//   state_o       : current controller state, for debug/status
//   modport slave  : controller side
//   modport master : system / driver side
// Revision    : 1.0 - initial release
// ============================================================================
interface rain_window_ctrl_if;

    logic       rain_sensor;
    logic       win_closed_sw;
    logic       win_open_sw;
    logic       auto_en;
    logic       manual_open;
    logic       motor_close;
    logic       motor_open;
    logic       rain_alarm;
    logic       fault;
    logic [2:0] state_o;

    modport slave (
        input  rain_sensor,
        input  win_closed_sw,
        input  win_open_sw,
        input  auto_en,
        input  manual_open,
        output motor_close,
        output motor_open,
        output rain_alarm,
        output fault,
        output state_o
    );

    modport master (
        output rain_sensor,
        output win_closed_sw,
        output win_open_sw,
        output auto_en,
        output manual_open,
        input  motor_close,
        input  motor_open,
        input  rain_alarm,
        input  fault,
        input  state_o
    );

endinterface : rain_window_ctrl_if
`default_nettype wire

// File: rtl/rain_window_ctrl_sensor_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sensor_debounce
// Description : Generic level debouncer. The filtered output changes only
//               after the raw input has disagreed with it for
//               DEBOUNCE_CYCLES consecutive sampled edges; any agreeing
//               sample restarts the count.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   raw   : raw sensor input
//   filt  : debounced level (0 after reset)
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filt
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_filt;

    // The counter holds the number of mismatching samples already seen, so
    // the mismatch observed while it sits at DEBOUNCE_CYCLES-1 is the last
    // one needed and flips the output on that same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else if (raw != r_filt) begin
            if (r_cnt >= C_LAST) begin
                r_filt <= ~r_filt;
                r_cnt  <= '0;
            end else begin
                r_cnt  <= r_cnt + C_ONE;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign filt = r_filt;

endmodule : sensor_debounce
`default_nettype wire

// File: rtl/rain_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rain_window_ctrl
// Description : Rain-driven window actuator sequencer. Debounces the rain
//               sensor, closes the window when it rains (auto mode), reopens
//               it after a dry hold period or on a manual request, and traps
//               into a sticky fault on motor timeout or contradictory limit
//               switches.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rain_window_ctrl_if.slave (sensors in, motors/status out)
// Revision    : 1.0 - initial release
// ============================================================================
module rain_window_ctrl
    import rain_window_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = C_DEBOUNCE_CYCLES_DEF,
    parameter int unsigned MOTOR_TIMEOUT   = C_MOTOR_TIMEOUT_DEF,
    parameter int unsigned DRY_HOLD        = C_DRY_HOLD_DEF,
    parameter int unsigned CNT_W           = C_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    rain_window_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] C_TMO_LAST = CNT_W'(MOTOR_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_DRY_LAST = CNT_W'(DRY_HOLD - 1);
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_motor_tmr;
    logic [CNT_W-1:0] r_dry_cnt;
    logic             w_rain_filt;
    logic             w_switch_conflict;
    logic             w_motor_expired;
    logic             w_dry_done;
    logic             r_motor_close;
    logic             r_motor_open;
    logic             r_fault;

    sensor_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_rain_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.rain_sensor),
        .filt  (w_rain_filt)
    );

    // Both limit switches active at once cannot happen mechanically, so it
    // indicates a wiring or sensor failure.
    assign w_switch_conflict = bus.win_closed_sw & bus.win_open_sw;

    // The timer holds the number of completed cycles in the motion state,
    // so seeing MOTOR_TIMEOUT-1 means the current cycle is the last allowed.
    assign w_motor_expired   = (r_motor_tmr >= C_TMO_LAST);
    assign w_dry_done        = (r_dry_cnt   >= C_DRY_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE_OPEN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if ((r_state != ST_FAULT) && w_switch_conflict) begin
            w_state_next = ST_FAULT;
        end else begin
            unique case (r_state)
                ST_IDLE_OPEN: begin
                    if (w_rain_filt && bus.auto_en) begin
                        w_state_next = bus.win_closed_sw ? ST_CLOSED : ST_CLOSING;
                    end
                end
                ST_CLOSING: begin
                    // Reaching the limit switch beats a simultaneous timeout.
                    if (bus.win_closed_sw) begin
                        w_state_next = ST_CLOSED;
                    end else if (w_motor_expired) begin
                        w_state_next = ST_FAULT;
                    end
                end
                ST_CLOSED: begin
                    if (!w_rain_filt) begin
                        w_state_next = bus.manual_open ? ST_OPENING : ST_WAIT_DRY;
                    end
                end
                ST_WAIT_DRY: begin
                    if (w_rain_filt) begin
                        w_state_next = ST_CLOSED;
                    end else if (bus.manual_open) begin
                        w_state_next = ST_OPENING;
                    end else if (w_dry_done && bus.auto_en) begin
                        w_state_next = ST_OPENING;
                    end
                end
                ST_OPENING: begin
                    if (bus.win_open_sw) begin
                        w_state_next = ST_IDLE_OPEN;
                    end else if (w_rain_filt) begin
                        w_state_next = ST_CLOSING;
                    end else if (w_motor_expired) begin
                        w_state_next = ST_FAULT;
                    end
                end
                ST_FAULT: begin
                    w_state_next = ST_FAULT;
                end
                default: begin
                    w_state_next = ST_FAULT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Motor timer and dry counter. Both restart on every state change;
    // a direct OPENING->CLOSING reversal therefore gets a fresh timeout.
    // Both saturate at their terminal value instead of wrapping.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_motor_tmr <= '0;
            r_dry_cnt   <= '0;
        end else if (w_state_next != r_state) begin
            r_motor_tmr <= '0;
            r_dry_cnt   <= '0;
        end else begin
            if (is_motion(r_state) && !w_motor_expired) begin
                r_motor_tmr <= r_motor_tmr + C_ONE;
            end
            if ((r_state == ST_WAIT_DRY) && !w_dry_done) begin
                r_dry_cnt <= r_dry_cnt + C_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered Moore outputs decoded from the next state so they switch
    // on the same edge as the state register. Reset clears them at once,
    // which stops the motor immediately.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_motor_close <= 1'b0;
            r_motor_open  <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_motor_close <= (w_state_next == ST_CLOSING);
            r_motor_open  <= (w_state_next == ST_OPENING);
            r_fault       <= (w_state_next == ST_FAULT);
        end
    end

    assign bus.motor_close = r_motor_close;
    assign bus.motor_open  = r_motor_open;
    assign bus.fault       = r_fault;
    assign bus.rain_alarm  = w_rain_filt;
    assign bus.state_o     = r_state;

endmodule : rain_window_ctrl
`default_nettype wire

// File: tb/tb_rain_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rain_window_ctrl
// Description : Directed self-checking bench for rain_window_ctrl using the
//               default parameters. Inputs change and outputs are sampled
//               1 time unit after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rain_window_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rain_window_ctrl_if bus ();

    rain_window_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [2:0] st,
                              input logic mc, input logic mo, input logic flt);
        check3({tag, ".state"},       bus.state_o,     st);
        check1({tag, ".motor_close"}, bus.motor_close, mc);
        check1({tag, ".motor_open"},  bus.motor_open,  mo);
        check1({tag, ".fault"},       bus.fault,       flt);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n             = 1'b0;
        bus.rain_sensor   = 1'b0;
        bus.win_closed_sw = 1'b0;
        bus.win_open_sw   = 1'b0;
        bus.auto_en       = 1'b1;
        bus.manual_open   = 1'b0;

        // Reset state
        #2;
        check_outs("reset", 3'd0, 1'b0, 1'b0, 1'b0);
        check1("reset.alarm", bus.rain_alarm, 1'b0);
        tick(2);
        rst_n = 1'b1;

        // Three-cycle glitch must not pass the debouncer
        bus.rain_sensor = 1'b1;
        tick(3);
        check1("glitch.alarm3", bus.rain_alarm, 1'b0);
        bus.rain_sensor = 1'b0;
        tick(5);
        check1("glitch.alarm", bus.rain_alarm, 1'b0);
        check_outs("glitch", 3'd0, 1'b0, 1'b0, 1'b0);

        // Rain for four edges -> alarm at 4th, CLOSING on the next
        bus.rain_sensor = 1'b1;
        tick(3);
        check1("rain.alarm3", bus.rain_alarm, 1'b0);
        tick(1);
        check1("rain.alarm4", bus.rain_alarm, 1'b1);
        check3("rain.state4", bus.state_o, 3'd0);
        tick(1);
        check_outs("closing", 3'd1, 1'b1, 1'b0, 1'b0);
        bus.win_closed_sw = 1'b1;
        tick(1);
        check_outs("closed", 3'd2, 1'b0, 1'b0, 1'b0);

        // Manual open ignored while it is raining
        bus.manual_open = 1'b1;
        tick(2);
        check_outs("closed_manual_wet", 3'd2, 1'b0, 1'b0, 1'b0);
        bus.manual_open = 1'b0;

        // Dry for four edges -> WAIT_DRY on the 5th, reopen after 16 more
        bus.rain_sensor = 1'b0;
        tick(4);
        check1("dry.alarm4", bus.rain_alarm, 1'b0);
        check3("dry.state4", bus.state_o, 3'd2);
        tick(1);
        check_outs("wait_dry", 3'd3, 1'b0, 1'b0, 1'b0);
        tick(15);
        check_outs("wait_dry15", 3'd3, 1'b0, 1'b0, 1'b0);
        tick(1);
        check_outs("opening", 3'd4, 1'b0, 1'b1, 1'b0);
        bus.win_closed_sw = 1'b0;

        // Rain during OPENING reverses the motor on a single edge
        bus.rain_sensor = 1'b1;
        tick(4);
        check_outs("opening_rain4", 3'd4, 1'b0, 1'b1, 1'b0);
        tick(1);
        check_outs("reverse", 3'd1, 1'b1, 1'b0, 1'b0);

        // No closed switch: fault after exactly 32 cycles in CLOSING
        tick(31);
        check_outs("closing31", 3'd1, 1'b1, 1'b0, 1'b0);
        tick(1);
        check_outs("timeout", 3'd5, 1'b0, 1'b0, 1'b1);

        // Fault is sticky against rain changes and manual open
        bus.rain_sensor = 1'b0;
        bus.manual_open = 1'b1;
        tick(10);
        check_outs("fault_sticky", 3'd5, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check_outs("fault_reset", 3'd0, 1'b0, 1'b0, 1'b0);
        tick(1);
        rst_n = 1'b1;
        bus.manual_open = 1'b0;

        // Rain with window already closed -> straight to CLOSED
        bus.rain_sensor   = 1'b1;
        bus.win_closed_sw = 1'b1;
        tick(4);
        check3("direct.state4", bus.state_o, 3'd0);
        tick(1);
        check_outs("direct_closed", 3'd2, 1'b0, 1'b0, 1'b0);
        bus.rain_sensor = 1'b0;
        tick(5);
        check3("direct.wait_dry", bus.state_o, 3'd3);
        bus.manual_open = 1'b1;
        tick(1);
        check_outs("manual_opening", 3'd4, 1'b0, 1'b1, 1'b0);
        bus.manual_open = 1'b0;

        // Both limit switches while OPENING -> FAULT on the next edge
        bus.win_open_sw = 1'b1;
        tick(1);
        check_outs("switch_conflict", 3'd5, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a close drops the motor immediately
        rst_n = 1'b0;
        bus.win_open_sw   = 1'b0;
        bus.win_closed_sw = 1'b0;
        tick(1);
        rst_n = 1'b1;
        bus.rain_sensor = 1'b1;
        tick(5);
        check_outs("midmotion_closing", 3'd1, 1'b1, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check_outs("midmotion_reset", 3'd0, 1'b0, 1'b0, 1'b0);
        tick(1);
        rst_n = 1'b1;

        // Automatic mode off: alarm follows rain, window untouched
        bus.auto_en = 1'b0;
        tick(10);
        check1("manual_mode.alarm", bus.rain_alarm, 1'b1);
        check_outs("manual_mode", 3'd0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rain_window_ctrl
`default_nettype wire
